alu_writeback_regfile: RTL
==========================

Name: alu_writeback_regfile

Overview:
- Downstream writeback stage for the ALU. It takes the ALU result C and Flags, holds them for one cycle in a pipeline register, then commits them to a register file and to the processor status register (PSR).
- The register file also supplies the ALU's A and B operands through two read ports that see the committed array plus a bypass from the pending entry.
- The PSR is fed back so the ALU receives its carry-in from committed state rather than from its own combinational feedback.

Parameters:
- DATA_WIDTH, 16, width of registers, C, A and B.
- ADDR_WIDTH, 4, register address width; NUM_REGS = 2**ADDR_WIDTH.
- FLAG_WIDTH, 6, width of the Flags vector and the PSR.
- R0_ZERO, 0, when 1, register 0 always reads 0 and ignores writes.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- InValid  input  1  the ALU result on C/Flags is valid this cycle.
- InReady  output  1  the stage accepts an input this cycle.
- C  input  DATA_WIDTH  ALU result.
- Flags  input  FLAG_WIDTH  ALU flags.
- WrAddr  input  ADDR_WIDTH  destination register.
- WrEn  input  1  write C to WrAddr.
- FlagMask  input  FLAG_WIDTH  per-bit PSR update enable.
- Stall  input  1  freeze the pending entry; no commit.
- RdAddrA  input  ADDR_WIDTH  read port A address.
- RdAddrB  input  ADDR_WIDTH  read port B address.
- A  output  DATA_WIDTH  operand A to the ALU (combinational).
- B  output  DATA_WIDTH  operand B to the ALU (combinational).
- Psr  output  FLAG_WIDTH  committed PSR, fed to the ALU.
- PendValid  output  1  a pending entry exists.

Behaviour:
- Reset (asynchronous):
  - all registers = 0, PSR = 0, pending register cleared, PendValid = 0.
  - A and B then read 0.
  - Reset mid-operation discards any pending entry without committing it.
- InReady = ~Stall | ~PendValid.
- An input is accepted when InValid & InReady. Acceptance latches C, Flags, WrAddr, WrEn and FlagMask into the pending register and sets PendValid.
- Two-state controller, states EMPTY and PENDING:
  - EMPTY -> PENDING on accept.
  - PENDING with ~Stall: commit the pending entry. On the same edge, either load a new accepted input (stay PENDING) or go to EMPTY.
  - PENDING with Stall: hold; no commit; InReady = 0.
  - EMPTY with Stall: an input may still be accepted. Stall only blocks the commit.
- Commit on edge N+1 for an input accepted on edge N. Latency from accept to architectural visibility is 1 cycle; the bypass below makes the value visible earlier.
  - If WrEn is set, regs[WrAddr] <= C. This is suppressed when R0_ZERO = 1 and WrAddr = 0.
  - PSR <= (PSR & ~FlagMask) | (Flags & FlagMask).
  - A FlagMask of 0 leaves the PSR unchanged, which is how logical ops preserve flags.
- Read ports, combinational:
  - If PendValid & pending WrEn & RdAddr == pending WrAddr (and not the R0_ZERO case), the output is the pending C (bypass).
  - Otherwise the output is regs[RdAddr].
  - With R0_ZERO = 1 and RdAddr = 0, the output is 0.
  - Both ports may hit the same address; both then return the same value.
- Psr reflects committed state only; pending flags are not bypassed. Upstream must not issue a carry-dependent op while PendValid is set with a nonzero pending FlagMask.
- Simultaneous commit and accept to the same WrAddr: the commit writes the old entry to the array and the new entry becomes pending. The next read returns the new entry via the bypass.
- WrEn = 0 with a nonzero FlagMask is legal: PSR-only update (CMP-style).
- All widths come from the parameters; no arithmetic is performed in this block.

Test Plan:
1. Reset, then read RdAddrA = 3 -> A = 0, Psr = 0, PendValid = 0, InReady = 1.
2. Accept C = 16'h0008, WrAddr = 5, WrEn = 1, FlagMask = 6'h3F, Flags = 6'b000001.
   - Same cycle after the edge, RdAddrA = 5 -> A = 0008 (bypass).
   - One edge later -> regs[5] = 0008, Psr = 000001, PendValid = 0.
3. Back-to-back accepts of WrAddr 2 (C = 1111) then WrAddr 2 (C = 2222) -> after the second edge B (RdAddrB = 2) = 2222; after the third edge regs[2] = 2222.
4. Stall = 1 while PENDING (C = 00AA to reg 7):
   - InReady = 0 and reg 7 stays 0 for 3 cycles while A via bypass = 00AA.
   - Release Stall -> commit on the next edge.
5. PSR = 6'b000011; accept WrEn = 0, FlagMask = 6'b000010, Flags = 0 -> after commit Psr = 6'b000001 and all registers unchanged.
6. Assert RESET asynchronously while PENDING to reg 4 -> PendValid = 0 immediately and regs[4] = 0 after RESET deasserts. Separately, with R0_ZERO = 1, write 16'hFFFF to reg 0 -> A (RdAddrA = 0) = 0 at all times.

Source files
------------

// File: rtl/alu_writeback_regfile.sv
// ALU writeback: one-entry pending register feeding a register file and the PSR.
// Read ports see the committed array plus a bypass from the pending entry; Stall only blocks commit.
module alu_writeback_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FLAG_WIDTH = 6,
  parameter bit R0_ZERO    = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATA_WIDTH-1:0] C,
  input  logic [FLAG_WIDTH-1:0] Flags,
  input  logic [ADDR_WIDTH-1:0] WrAddr,
  input  logic                  WrEn,
  input  logic [FLAG_WIDTH-1:0] FlagMask,
  input  logic                  Stall,
  input  logic [ADDR_WIDTH-1:0] RdAddrA,
  input  logic [ADDR_WIDTH-1:0] RdAddrB,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [FLAG_WIDTH-1:0] Psr,
  output logic                  PendValid
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  typedef enum logic {EMPTY = 1'b0, PENDING = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pend_c_q;
  logic [FLAG_WIDTH-1:0]   pend_flags_q;
  logic [FLAG_WIDTH-1:0]   pend_mask_q;
  logic [ADDR_WIDTH-1:0]   pend_addr_q;
  logic                    pend_wren_q;
  logic [FLAG_WIDTH-1:0]   psr_q, psr_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

  logic accept, commit, wr_reg;
  logic r0_a, r0_b, hit_a, hit_b;

  assign PendValid = (state_q == PENDING);
  assign InReady   = ~Stall | ~PendValid;
  assign accept    = InValid & InReady;

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = PENDING;
      end
      PENDING: begin
        if (!Stall) begin
          commit  = 1'b1;
          state_d = accept ? PENDING : EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Register 0 is hardwired when R0_ZERO is set, so its writes are dropped here.
  assign wr_reg = commit & pend_wren_q & ~(R0_ZERO && (pend_addr_q == '0));
  assign psr_d  = commit ? ((psr_q & ~pend_mask_q) | (pend_flags_q & pend_mask_q)) : psr_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= EMPTY;
      pend_c_q     <= '0;
      pend_flags_q <= '0;
      pend_mask_q  <= '0;
      pend_addr_q  <= '0;
      pend_wren_q  <= 1'b0;
      psr_q        <= '0;
    end else begin
      state_q <= state_d;
      psr_q   <= psr_d;
      if (accept) begin
        pend_c_q     <= C;
        pend_flags_q <= Flags;
        pend_mask_q  <= FlagMask;
        pend_addr_q  <= WrAddr;
        pend_wren_q  <= WrEn;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_reg) begin
      regs_q[pend_addr_q] <= pend_c_q;
    end
  end

  assign r0_a  = R0_ZERO && (RdAddrA == '0);
  assign r0_b  = R0_ZERO && (RdAddrB == '0);
  assign hit_a = PendValid & pend_wren_q & (RdAddrA == pend_addr_q);
  assign hit_b = PendValid & pend_wren_q & (RdAddrB == pend_addr_q);

  assign A   = r0_a ? '0 : (hit_a ? pend_c_q : regs_q[RdAddrA]);
  assign B   = r0_b ? '0 : (hit_b ? pend_c_q : regs_q[RdAddrB]);
  assign Psr = psr_q;

endmodule
